// File: rtl/hwpf_req_filter.sv
`default_nettype none
// ============================================================================
// Module   : hwpf_req_filter
// Brief    : Prefetch request FIFO that drops requests whose cache line is
//            already queued or was recently issued (history table).
// Revision : 1.0 - initial release
// ============================================================================
module hwpf_req_filter #(
  parameter int unsigned NLINE_WIDTH  = 43,
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned HIST_ENTRIES = 8,
  parameter int unsigned CNT_WIDTH    = 16,
  parameter type         hpdcache_req_t = logic
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   enable_i,
  input  logic                   flush_i,
  input  logic                   drop_cnt_clr_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  hpdcache_req_t          in_req_i,
  input  logic [NLINE_WIDTH-1:0] in_nline_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output hpdcache_req_t          out_req_o,
  output logic [CNT_WIDTH-1:0]   drop_cnt_o
);

  localparam int unsigned     c_CW    = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned     c_HW    = (HIST_ENTRIES > 1) ? $clog2(HIST_ENTRIES) : 1;
  localparam logic [c_CW-1:0] c_FULL  = c_CW'(FIFO_DEPTH);
  localparam logic [c_HW-1:0] c_HLAST = c_HW'(HIST_ENTRIES - 1);

  // Shift-register FIFO: entry 0 is always the head.
  hpdcache_req_t          r_fifo_req   [FIFO_DEPTH];
  logic [NLINE_WIDTH-1:0] r_fifo_nline [FIFO_DEPTH];
  logic [c_CW-1:0]        r_cnt;

  logic [NLINE_WIDTH-1:0] r_hist_nline [HIST_ENTRIES];
  logic [HIST_ENTRIES-1:0] r_hist_vld;
  logic [c_HW-1:0]        r_hist_wptr;
  logic [CNT_WIDTH-1:0]   r_drop_cnt;

  hpdcache_req_t          w_next_req   [FIFO_DEPTH];
  logic [NLINE_WIDTH-1:0] w_next_nline [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]  w_fifo_match;
  logic [HIST_ENTRIES-1:0] w_hist_match;
  logic                   w_hit;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_accept;
  logic                   w_push;
  logic                   w_drop;
  logic                   w_pop;
  logic [c_CW-1:0]        w_push_idx;

  for (genvar i = 0; i < FIFO_DEPTH; i++) begin : g_fifo_cmp
    assign w_fifo_match[i] = (c_CW'(i) < r_cnt) && (r_fifo_nline[i] == in_nline_i);
    if (i < FIFO_DEPTH - 1) begin : g_shift
      assign w_next_req[i]   = r_fifo_req[i+1];
      assign w_next_nline[i] = r_fifo_nline[i+1];
    end else begin : g_tail
      assign w_next_req[i]   = r_fifo_req[i];
      assign w_next_nline[i] = r_fifo_nline[i];
    end
  end

  for (genvar i = 0; i < HIST_ENTRIES; i++) begin : g_hist_cmp
    assign w_hist_match[i] = r_hist_vld[i] && (r_hist_nline[i] == in_nline_i);
  end

  assign w_hit      = enable_i && ((|w_fifo_match) || (|w_hist_match));
  assign w_full     = (r_cnt == c_FULL);
  assign w_empty    = (r_cnt == '0);
  // Ready is a function of state and input data only, never of out_ready_i.
  assign in_ready_o = !w_full || w_hit;
  assign w_accept   = in_valid_i && in_ready_o;
  assign w_push     = w_accept && !w_hit;
  assign w_drop     = w_accept && w_hit;
  assign w_pop      = !w_empty && out_ready_i;
  assign w_push_idx = w_pop ? (r_cnt - c_CW'(1)) : r_cnt;

  assign out_valid_o = !w_empty;
  assign out_req_o   = r_fifo_req[0];
  assign drop_cnt_o  = r_drop_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_req[i]   <= '0;
        r_fifo_nline[i] <= '0;
      end
      r_cnt <= '0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (w_push && (w_push_idx == c_CW'(i))) begin
          r_fifo_req[i]   <= in_req_i;
          r_fifo_nline[i] <= in_nline_i;
        end else if (w_pop) begin
          r_fifo_req[i]   <= w_next_req[i];
          r_fifo_nline[i] <= w_next_nline[i];
        end
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + c_CW'(1);
        2'b01:   r_cnt <= r_cnt - c_CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Flush beats a same-cycle pop for the valid bit, but the pointer still advances.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < HIST_ENTRIES; i++) begin
        r_hist_nline[i] <= '0;
      end
      r_hist_vld  <= '0;
      r_hist_wptr <= '0;
    end else begin
      if (w_pop) begin
        r_hist_nline[r_hist_wptr] <= r_fifo_nline[0];
        r_hist_wptr <= (r_hist_wptr == c_HLAST) ? '0 : (r_hist_wptr + c_HW'(1));
      end
      if (flush_i) begin
        r_hist_vld <= '0;
      end else if (w_pop) begin
        r_hist_vld[r_hist_wptr] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_drop_cnt <= '0;
    end else if (drop_cnt_clr_i) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != '1)) begin
      r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hwpf_req_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_hwpf_req_filter
// Brief    : Directed vector bench for hwpf_req_filter (default + 4-bit counter).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hwpf_req_filter;

  typedef logic [15:0] req_t;

  typedef struct {
    bit          rst_n;
    bit          en;
    bit          fl;
    bit          clr;
    bit          vld;
    logic [15:0] nl;
    bit          ordy;
    bit          e_irdy;
    bit          e_ovld;
    logic [15:0] e_out;
    int          e_drop;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        en, fl, clr, vld, ordy;
  logic [15:0] nl;
  logic [42:0] nline;
  req_t        req;
  logic        irdy_a, ovld_a, irdy_b, ovld_b;
  req_t        out_a, out_b;
  logic [15:0] drop_a;
  logic [3:0]  drop_b;

  int n_vec = 0;
  int n_bad = 0;
  vec_t vecs[$];

  function automatic req_t pay(input logic [15:0] n);
    return n ^ 16'hA5A5;
  endfunction

  assign nline = {27'b0, nl};
  assign req   = pay(nl);

  hwpf_req_filter #(.hpdcache_req_t(req_t)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .flush_i(fl), .drop_cnt_clr_i(clr),
    .in_valid_i(vld), .in_ready_o(irdy_a), .in_req_i(req), .in_nline_i(nline),
    .out_valid_o(ovld_a), .out_ready_i(ordy), .out_req_o(out_a), .drop_cnt_o(drop_a)
  );

  hwpf_req_filter #(.CNT_WIDTH(4), .hpdcache_req_t(req_t)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .flush_i(fl), .drop_cnt_clr_i(clr),
    .in_valid_i(vld), .in_ready_o(irdy_b), .in_req_i(req), .in_nline_i(nline),
    .out_valid_o(ovld_b), .out_ready_i(ordy), .out_req_o(out_b), .drop_cnt_o(drop_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic v(input bit r, input bit e, input bit f, input bit c, input bit va,
                   input logic [15:0] n, input bit o, input bit ei, input bit eo,
                   input logic [15:0] eq, input int ed);
    vecs.push_back('{rst_n: r, en: e, fl: f, clr: c, vld: va, nl: n, ordy: o,
                     e_irdy: ei, e_ovld: eo, e_out: eq, e_drop: ed});
  endtask

  task automatic drive(input bit r, input bit e, input bit f, input bit c, input bit va,
                       input logic [15:0] n, input bit o);
    rst_n = r; en = e; fl = f; clr = c; vld = va; nl = n; ordy = o;
  endtask

  initial begin
    drive(0, 1, 0, 0, 0, 16'h0, 1);
    repeat (2) @(negedge clk);

    //  rst en fl clr vld nline  ordy | irdy ovld out    drop
    v(1, 1, 0, 0, 0, 16'h000, 1,   1, 0, 16'h000, 0);
    // back-to-back duplicate
    v(1, 1, 0, 0, 1, 16'h100, 1,   1, 0, 16'h000, 0);
    v(1, 1, 0, 0, 1, 16'h100, 1,   1, 1, 16'h100, 0);
    v(1, 1, 0, 0, 0, 16'h000, 1,   1, 0, 16'h000, 1);
    // history eviction: 0..8 streamed, 0 evicted, 1 still recorded
    v(1, 1, 0, 0, 1, 16'h000, 1,   1, 0, 16'h000, 1);
    for (int n = 1; n <= 8; n++) v(1, 1, 0, 0, 1, 16'(n), 1, 1, 1, 16'(n - 1), 1);
    v(1, 1, 0, 0, 0, 16'h000, 1,   1, 1, 16'h008, 1);
    v(1, 1, 0, 0, 1, 16'h000, 1,   1, 0, 16'h000, 1);
    v(1, 1, 0, 0, 1, 16'h001, 1,   1, 1, 16'h000, 1);
    v(1, 1, 0, 0, 0, 16'h000, 1,   1, 0, 16'h000, 2);
    // full FIFO backpressure, hit accepted while full, no pass-through on pop
    v(1, 1, 0, 0, 1, 16'h010, 0,   1, 0, 16'h000, 2);
    v(1, 1, 0, 0, 1, 16'h011, 0,   1, 1, 16'h010, 2);
    v(1, 1, 0, 0, 1, 16'h012, 0,   0, 1, 16'h010, 2);
    v(1, 1, 0, 0, 1, 16'h011, 0,   1, 1, 16'h010, 2);
    v(1, 1, 0, 0, 0, 16'h012, 0,   0, 1, 16'h010, 3);
    v(1, 1, 0, 0, 1, 16'h012, 1,   0, 1, 16'h010, 3);
    v(1, 1, 0, 0, 0, 16'h000, 1,   1, 1, 16'h011, 3);
    v(1, 1, 0, 0, 0, 16'h000, 1,   1, 0, 16'h000, 3);
    // flush: pre-flush compare, then forwarded again; flush wins over pop
    v(1, 1, 0, 0, 1, 16'h020, 1,   1, 0, 16'h000, 3);
    v(1, 1, 0, 0, 0, 16'h000, 1,   1, 1, 16'h020, 3);
    v(1, 1, 0, 0, 1, 16'h020, 1,   1, 0, 16'h000, 3);
    v(1, 1, 1, 0, 1, 16'h020, 1,   1, 0, 16'h000, 4);
    v(1, 1, 0, 0, 1, 16'h020, 1,   1, 0, 16'h000, 5);
    v(1, 1, 1, 0, 0, 16'h000, 1,   1, 1, 16'h020, 5);
    v(1, 1, 0, 0, 1, 16'h020, 1,   1, 0, 16'h000, 5);
    v(1, 1, 0, 0, 0, 16'h000, 1,   1, 1, 16'h020, 5);
    // clear beats a same-cycle increment
    v(1, 1, 0, 1, 1, 16'h020, 1,   1, 0, 16'h000, 5);
    v(1, 1, 0, 0, 0, 16'h000, 1,   1, 0, 16'h000, 0);
    // disabled: everything forwarded, history still recorded
    v(1, 0, 0, 0, 1, 16'h030, 1,   1, 0, 16'h000, 0);
    v(1, 0, 0, 0, 1, 16'h030, 1,   1, 1, 16'h030, 0);
    v(1, 0, 0, 0, 1, 16'h030, 1,   1, 1, 16'h030, 0);
    v(1, 0, 0, 0, 0, 16'h000, 1,   1, 1, 16'h030, 0);
    v(1, 0, 0, 0, 0, 16'h000, 1,   1, 0, 16'h000, 0);
    v(1, 1, 0, 0, 1, 16'h030, 1,   1, 0, 16'h000, 0);
    v(1, 1, 0, 0, 0, 16'h000, 1,   1, 0, 16'h000, 1);
    // async reset with a full FIFO
    v(1, 1, 0, 0, 1, 16'h040, 0,   1, 0, 16'h000, 1);
    v(1, 1, 0, 0, 1, 16'h041, 0,   1, 1, 16'h040, 1);
    v(0, 1, 0, 0, 0, 16'h000, 0,   1, 0, 16'h000, 0);
    v(1, 1, 0, 0, 1, 16'h040, 1,   1, 0, 16'h000, 0);
    v(1, 1, 0, 0, 1, 16'h041, 1,   1, 1, 16'h040, 0);
    v(1, 1, 0, 0, 0, 16'h000, 1,   1, 1, 16'h041, 0);
    v(1, 1, 0, 0, 0, 16'h000, 1,   1, 0, 16'h000, 0);

    foreach (vecs[k]) begin
      @(negedge clk);
      drive(vecs[k].rst_n, vecs[k].en, vecs[k].fl, vecs[k].clr, vecs[k].vld,
            vecs[k].nl, vecs[k].ordy);
      #1;
      chk($sformatf("v%0d in_ready", k), {31'b0, irdy_a}, {31'b0, vecs[k].e_irdy});
      chk($sformatf("v%0d out_valid", k), {31'b0, ovld_a}, {31'b0, vecs[k].e_ovld});
      if (vecs[k].e_ovld)
        chk($sformatf("v%0d out_req", k), {16'b0, out_a}, {16'b0, pay(vecs[k].e_out)});
      chk($sformatf("v%0d drop_cnt", k), {16'b0, drop_a}, 32'(vecs[k].e_drop));
    end

    // 17 drops of one line: 16-bit counter counts, 4-bit counter saturates
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      drive(1, 1, 0, 0, 1, 16'h050, 1);
      #1;
      if (k == 16) begin
        chk("sat15 drop_a", {16'b0, drop_a}, 32'd15);
        chk("sat15 drop_b", {28'b0, drop_b}, 32'd15);
      end
    end
    @(negedge clk);
    drive(1, 1, 0, 1, 0, 16'h000, 1);
    #1;
    chk("sat17 drop_a", {16'b0, drop_a}, 32'd17);
    chk("sat17 drop_b", {28'b0, drop_b}, 32'd15);
    chk("sat17 out_valid", {31'b0, ovld_b}, 32'd0);
    @(negedge clk);
    drive(1, 1, 0, 0, 0, 16'h000, 1);
    #1;
    chk("clr drop_a", {16'b0, drop_a}, 32'd0);
    chk("clr drop_b", {28'b0, drop_b}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
